// File: rtl/bpu_pkg.sv
// Shared helpers for the set-associative BTB/BHT: derived-size functions,
// saturating-counter arithmetic and the weakly-taken / weakly-not-taken encodings.
package bpu_pkg;

    function automatic int unsigned index_len(input int unsigned sets);
        return (sets <= 1) ? 0 : $clog2(sets);
    endfunction

    function automatic int unsigned tag_len(input int unsigned addr_width,
                                            input int unsigned index_begin,
                                            input int unsigned idx_len);
        return addr_width - index_begin - idx_len;
    endfunction

    function automatic int unsigned way_bits(input int unsigned ways);
        return (ways <= 1) ? 1 : $clog2(ways);
    endfunction

    function automatic int unsigned wt_state(input int unsigned state_num);
        return 32'd1 << (state_num - 1);
    endfunction

    function automatic int unsigned wnt_state(input int unsigned state_num);
        return (32'd1 << (state_num - 1)) - 32'd1;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned state_num);
        return (v >= (32'd1 << state_num) - 32'd1) ? v : v + 32'd1;
    endfunction

    function automatic int unsigned sat_dec(input int unsigned v);
        return (v == 0) ? 0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/bpu_assoc_btb_set_lookup.sv
// Combinational tag compare across the ways of one set; lowest way wins on
// both the hit search and the first-invalid search.
module bpu_set_lookup #(
    parameter int unsigned WAYS    = 2,
    parameter int unsigned TAG_LEN = 58,
    parameter int unsigned WAY_W   = 1
) (
    input  logic [WAYS-1:0]              valid,
    input  logic [WAYS-1:0][TAG_LEN-1:0] tags,
    input  logic [TAG_LEN-1:0]           tag,
    output logic                         hit,
    output logic [WAY_W-1:0]             hit_way,
    output logic [WAY_W-1:0]             first_invalid_way,
    output logic                         any_invalid
);

    always_comb begin
        hit               = 1'b0;
        hit_way           = '0;
        any_invalid       = 1'b0;
        first_invalid_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && valid[w] && (tags[w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!any_invalid && !valid[w]) begin
                any_invalid       = 1'b1;
                first_invalid_way = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/bpu_assoc_btb.sv
// N-way set-associative BTB/BHT: combinational IF lookup, registered EXE
// update/allocation with per-set round-robin replacement and global flush.
module bpu_assoc_btb
    import bpu_pkg::*;
#(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WAYS        = 2,
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned STATE_NUM   = 2,
    parameter int unsigned INDEX_BEGIN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] pc_if,
    output logic                  hit_if,
    output logic                  jump_if,
    output logic [ADDR_WIDTH-1:0] pc_target_if,
    input  logic [ADDR_WIDTH-1:0] pc_exe,
    input  logic [ADDR_WIDTH-1:0] pc_target_exe,
    input  logic                  jump_exe,
    input  logic                  is_jump_exe
);

    localparam int unsigned SETS      = DEPTH / WAYS;
    localparam int unsigned INDEX_LEN = index_len(SETS);
    localparam int unsigned INDEX_W   = (INDEX_LEN == 0) ? 1 : INDEX_LEN;
    localparam int unsigned TAG_LEN   = tag_len(ADDR_WIDTH, INDEX_BEGIN, INDEX_LEN);
    localparam int unsigned WAY_W     = way_bits(WAYS);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [TAG_LEN-1:0]    tag_t;
    typedef logic [INDEX_W-1:0]    index_t;
    typedef logic [STATE_NUM-1:0]  state_t;
    typedef logic [WAY_W-1:0]      way_t;

    typedef struct packed {
        logic   valid;
        tag_t   tag;
        addr_t  target;
        state_t state;
    } btb_entry_t;

    localparam state_t WT  = state_t'(wt_state(STATE_NUM));
    localparam state_t WNT = state_t'(wnt_state(STATE_NUM));

    btb_entry_t [WAYS-1:0] entry_q [SETS];
    way_t                  ptr_q   [SETS];

    index_t idx_if, idx_exe;
    tag_t   tag_if, tag_exe;

    assign tag_if  = pc_if[ADDR_WIDTH-1 -: TAG_LEN];
    assign tag_exe = pc_exe[ADDR_WIDTH-1 -: TAG_LEN];

    if (INDEX_LEN > 0) begin : g_index
        assign idx_if  = pc_if[INDEX_BEGIN +: INDEX_LEN];
        assign idx_exe = pc_exe[INDEX_BEGIN +: INDEX_LEN];
    end else begin : g_no_index
        assign idx_if  = '0;
        assign idx_exe = '0;
    end

    if (INDEX_BEGIN > 0) begin : g_low_bits
        logic unused_low_bits;
        assign unused_low_bits = ^{pc_if[INDEX_BEGIN-1:0], pc_exe[INDEX_BEGIN-1:0]};
    end

    logic [WAYS-1:0]          valid_if, valid_exe;
    logic [WAYS-1:0][TAG_LEN-1:0] tags_if, tags_exe;

    always_comb begin
        valid_if  = '0;
        valid_exe = '0;
        tags_if   = '0;
        tags_exe  = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            valid_if[w]  = entry_q[idx_if][w].valid;
            tags_if[w]   = entry_q[idx_if][w].tag;
            valid_exe[w] = entry_q[idx_exe][w].valid;
            tags_exe[w]  = entry_q[idx_exe][w].tag;
        end
    end

    logic hit_exe, any_invalid_exe;
    way_t hit_way_if, hit_way_exe, first_invalid_exe;
    way_t if_free_way_unused;
    logic if_any_free_unused;

    bpu_set_lookup #(.WAYS(WAYS), .TAG_LEN(TAG_LEN), .WAY_W(WAY_W)) u_lookup_if (
        .valid             (valid_if),
        .tags              (tags_if),
        .tag               (tag_if),
        .hit               (hit_if),
        .hit_way           (hit_way_if),
        .first_invalid_way (if_free_way_unused),
        .any_invalid       (if_any_free_unused)
    );

    bpu_set_lookup #(.WAYS(WAYS), .TAG_LEN(TAG_LEN), .WAY_W(WAY_W)) u_lookup_exe (
        .valid             (valid_exe),
        .tags              (tags_exe),
        .tag               (tag_exe),
        .hit               (hit_exe),
        .hit_way           (hit_way_exe),
        .first_invalid_way (first_invalid_exe),
        .any_invalid       (any_invalid_exe)
    );

    assign jump_if      = hit_if && entry_q[idx_if][hit_way_if].state[STATE_NUM-1];
    assign pc_target_if = jump_if ? entry_q[idx_if][hit_way_if].target
                                  : pc_if + ADDR_WIDTH'(4);

    state_t state_exe, state_exe_next;
    way_t   victim, ptr_cur, ptr_next;

    always_comb begin
        state_exe      = entry_q[idx_exe][hit_way_exe].state;
        state_exe_next = jump_exe ? state_t'(sat_inc(32'(state_exe), STATE_NUM))
                                  : state_t'(sat_dec(32'(state_exe)));
        ptr_cur        = ptr_q[idx_exe];
        ptr_next       = (ptr_cur == way_t'(WAYS - 1)) ? '0 : ptr_cur + 1'b1;
        victim         = any_invalid_exe ? first_invalid_exe : ptr_cur;
    end

    // Only valid/state/pointer are reset; tag/target are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    entry_q[s][w].valid <= 1'b0;
                    entry_q[s][w].state <= WNT;
                end
            end
        end else if (flush) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    entry_q[s][w].valid <= 1'b0;
                end
            end
        end else if (is_jump_exe) begin
            if (hit_exe) begin
                entry_q[idx_exe][hit_way_exe].state <= state_exe_next;
                if (jump_exe) begin
                    entry_q[idx_exe][hit_way_exe].target <= pc_target_exe;
                end
            end else if (jump_exe) begin
                entry_q[idx_exe][victim] <= '{valid: 1'b1, tag: tag_exe,
                                              target: pc_target_exe, state: WT};
                if (!any_invalid_exe) begin
                    ptr_q[idx_exe] <= ptr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_bpu_assoc_btb.sv
// Directed self-checking bench for bpu_assoc_btb (32 entries, 2 ways, 2-bit counters).
module tb_bpu_assoc_btb;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [63:0] pc_if;
    logic        hit_if;
    logic        jump_if;
    logic [63:0] pc_target_if;
    logic [63:0] pc_exe;
    logic [63:0] pc_target_exe;
    logic        jump_exe;
    logic        is_jump_exe;

    int checks   = 0;
    int failures = 0;

    bpu_assoc_btb #(
        .DEPTH       (32),
        .WAYS        (2),
        .ADDR_WIDTH  (64),
        .STATE_NUM   (2),
        .INDEX_BEGIN (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .pc_if         (pc_if),
        .hit_if        (hit_if),
        .jump_if       (jump_if),
        .pc_target_if  (pc_target_if),
        .pc_exe        (pc_exe),
        .pc_target_exe (pc_target_exe),
        .jump_exe      (jump_exe),
        .is_jump_exe   (is_jump_exe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [63:0] pc,
                        input logic exp_hit, input logic exp_jump, input logic [63:0] exp_tgt);
        pc_if = pc;
        #1;
        chk({tag, ".hit"},    64'(hit_if),   64'(exp_hit));
        chk({tag, ".jump"},   64'(jump_if),  64'(exp_jump));
        chk({tag, ".target"}, pc_target_if,  exp_tgt);
    endtask

    task automatic exe(input logic [63:0] pc, input logic [63:0] tgt, input logic taken);
        @(negedge clk);
        pc_exe        = pc;
        pc_target_exe = tgt;
        jump_exe      = taken;
        is_jump_exe   = 1'b1;
        @(negedge clk);
        is_jump_exe   = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pc_if = '0; pc_exe = '0;
        pc_target_exe = '0; jump_exe = 1'b0; is_jump_exe = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        look("reset", 64'h100, 1'b0, 1'b0, 64'h104);

        exe(64'h100, 64'h200, 1'b1);
        look("alloc", 64'h100, 1'b1, 1'b1, 64'h200);

        // counter walk: 2 -> 3 -> 3 -> 2 -> 1 -> 0 -> 0 -> 1 -> 2
        exe(64'h100, 64'h200, 1'b1);
        exe(64'h100, 64'h200, 1'b1);
        exe(64'h100, 64'h200, 1'b0);
        look("sat_hi_nt1", 64'h100, 1'b1, 1'b1, 64'h200);
        exe(64'h100, 64'h200, 1'b0);
        look("nt2", 64'h100, 1'b1, 1'b0, 64'h104);
        exe(64'h100, 64'h200, 1'b0);
        exe(64'h100, 64'h200, 1'b0);
        exe(64'h100, 64'h280, 1'b1);
        look("sat_lo_t1", 64'h100, 1'b1, 1'b0, 64'h104);
        exe(64'h100, 64'h280, 1'b1);
        look("sat_lo_t2", 64'h100, 1'b1, 1'b1, 64'h280);

        pulse_flush();
        look("flush_only", 64'h100, 1'b0, 1'b0, 64'h104);

        // replacement in set 0
        exe(64'h100, 64'hA00, 1'b1);
        exe(64'h140, 64'hA40, 1'b1);
        exe(64'h180, 64'hA80, 1'b1);
        look("repl_100", 64'h100, 1'b0, 1'b0, 64'h104);
        look("repl_140", 64'h140, 1'b1, 1'b1, 64'hA40);
        look("repl_180", 64'h180, 1'b1, 1'b1, 64'hA80);
        exe(64'h1C0, 64'hAC0, 1'b1);
        look("repl2_140", 64'h140, 1'b0, 1'b0, 64'h144);
        look("repl2_180", 64'h180, 1'b1, 1'b1, 64'hA80);
        look("repl2_1c0", 64'h1C0, 1'b1, 1'b1, 64'hAC0);

        exe(64'h300, 64'h999, 1'b0);
        look("nt_absent", 64'h300, 1'b0, 1'b0, 64'h304);
        look("nt_absent_keep", 64'h180, 1'b1, 1'b1, 64'hA80);

        look("wrap", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 64'h2);

        // same-cycle lookup and allocation: no bypass
        pulse_flush();
        @(negedge clk);
        pc_if = 64'h100; pc_exe = 64'h100; pc_target_exe = 64'hB00;
        jump_exe = 1'b1; is_jump_exe = 1'b1;
        #1;
        chk("same_cycle.hit", 64'(hit_if), 64'(1'b0));
        @(negedge clk);
        is_jump_exe = 1'b0;
        #1;
        chk("next_cycle.hit", 64'(hit_if), 64'(1'b1));
        chk("next_cycle.target", pc_target_if, 64'hB00);

        // flush drops a simultaneous allocation
        @(negedge clk);
        flush = 1'b1; pc_exe = 64'h240; pc_target_exe = 64'hC40;
        jump_exe = 1'b1; is_jump_exe = 1'b1;
        @(negedge clk);
        flush = 1'b0; is_jump_exe = 1'b0;
        look("flush_upd_100", 64'h100, 1'b0, 1'b0, 64'h104);
        look("flush_upd_240", 64'h240, 1'b0, 1'b0, 64'h244);

        // leave set-0 pointer at 1, then reset with a concurrent update
        exe(64'h100, 64'hD00, 1'b1);
        exe(64'h140, 64'hD40, 1'b1);
        exe(64'h180, 64'hD80, 1'b1);
        look("pre_rst_180", 64'h180, 1'b1, 1'b1, 64'hD80);
        @(negedge clk);
        rst = 1'b1; pc_exe = 64'h1C0; pc_target_exe = 64'hDC0;
        jump_exe = 1'b1; is_jump_exe = 1'b1;
        @(negedge clk);
        rst = 1'b0; is_jump_exe = 1'b0;
        look("rst_180", 64'h180, 1'b0, 1'b0, 64'h184);
        look("rst_1c0", 64'h1C0, 1'b0, 1'b0, 64'h1C4);

        // pointer back at 0 after reset: third allocation evicts way0
        exe(64'h100, 64'hE00, 1'b1);
        exe(64'h140, 64'hE40, 1'b1);
        exe(64'h180, 64'hE80, 1'b1);
        look("rst_ptr_100", 64'h100, 1'b0, 1'b0, 64'h104);
        look("rst_ptr_140", 64'h140, 1'b1, 1'b1, 64'hE40);
        look("rst_ptr_180", 64'h180, 1'b1, 1'b1, 64'hE80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
